// File: rtl/pack_ctrl_if.sv
// pack_ctrl_if: code intake, array write and packed-word handshake bundle for pack_ctrl
interface pack_ctrl_if #(parameter int CNT_W = 16);
  logic code_valid, code_ready, code_last;
  logic [7:0] code_len;
  logic arr_enable, arr_push_flag;
  logic [7:0] arr_push_amount;
  logic out_valid, out_ready, out_last;
  logic [7:0] out_bits;
  logic [CNT_W-1:0] word_count;
  logic len_err;
  modport master(
    output code_valid, code_len, code_last, out_ready,
    input code_ready, arr_enable, arr_push_flag, arr_push_amount,
    input out_valid, out_bits, out_last, word_count, len_err
  );
  modport slave(
    input code_valid, code_len, code_last, out_ready,
    output code_ready, arr_enable, arr_push_flag, arr_push_amount,
    output out_valid, out_bits, out_last, word_count, len_err
  );
endinterface

// File: rtl/pack_ctrl.sv
// pack_ctrl: sequences variable-length codes into reg_array2 and emits full or flushed packed words
module pack_ctrl #(
  parameter int TOTAL_WIDTH = 128,
  parameter int CNT_W = 16
) (
  input logic i_clk,
  input logic i_reset,
  pack_ctrl_if.slave bus
);
  localparam int FW = $clog2(2 * TOTAL_WIDTH) + 1;
  localparam logic [7:0] TW8 = 8'(TOTAL_WIDTH);
  localparam logic [FW-1:0] TW = FW'(TOTAL_WIDTH);
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t state, state_n;
  logic [FW-1:0] fill, fill_n, new_fill, out_bits;
  logic [7:0] len_eff;
  logic pend_last, pend_n, accept, take, out_last, bad_len;
  logic [CNT_W-1:0] word_count;
  logic len_err;
  always_comb begin
    bad_len = bus.code_len == 8'd0 || bus.code_len > TW8;
    len_eff = bus.code_len > TW8 ? TW8 : bus.code_len;
    accept = state == ACCUM && bus.code_valid;
    take = state == EMIT && bus.out_ready;
    new_fill = fill + FW'(len_eff);
    out_bits = fill > TW ? TW : fill;
    out_last = state == EMIT && pend_last && fill <= TW;
    state_n = state;
    fill_n = fill;
    pend_n = pend_last;
    if (accept) begin
      fill_n = new_fill;
      pend_n = bus.code_last && new_fill != '0;
      state_n = (new_fill >= TW || (bus.code_last && new_fill != '0)) ? EMIT : ACCUM;
    end
    if (take) begin
      fill_n = fill - out_bits;
      pend_n = pend_last && !out_last;
      // a last-block overflow keeps flushing until the residual is drained
      state_n = (pend_last && fill_n != '0) ? EMIT : ACCUM;
    end
  end
  always_ff @(posedge i_clk)
    if (!i_reset) begin
      state <= ACCUM;
      fill <= '0;
      pend_last <= 1'b0;
      word_count <= '0;
      len_err <= 1'b0;
    end else begin
      state <= state_n;
      fill <= fill_n;
      pend_last <= pend_n;
      if (take && !(&word_count)) word_count <= word_count + 1'b1;
      if (accept && bad_len) len_err <= 1'b1;
    end
  assign bus.code_ready = state == ACCUM;
  assign bus.arr_enable = accept && bus.code_len != 8'd0;
  assign bus.arr_push_flag = accept && fill != '0;
  assign bus.arr_push_amount = accept ? 8'(fill) : 8'd0;
  assign bus.out_valid = state == EMIT;
  assign bus.out_bits = state == EMIT ? 8'(out_bits) : 8'd0;
  assign bus.out_last = out_last;
  assign bus.word_count = word_count;
  assign bus.len_err = len_err;
endmodule

// File: tb/tb_pack_ctrl.sv
// tb_pack_ctrl: directed checks of pack_ctrl fill tracking, word emission, flush, stall and reset
module tb_pack_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  pack_ctrl_if #(.CNT_W(16)) bus();
  pack_ctrl #(.TOTAL_WIDTH(128), .CNT_W(16)) dut(.i_clk(clk), .i_reset(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.code_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic code(input int len, input bit last, input int amt, input bit flag, input bit en);
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code_len = 8'(len);
    bus.code_last = last;
    #1;
    chk("code_ready", bus.code_ready, 1);
    chk("arr_enable", bus.arr_enable, en);
    chk("push_amount", bus.arr_push_amount, amt);
    chk("push_flag", bus.arr_push_flag, flag);
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.code_last = 1'b0;
  endtask
  task automatic take(input int bits, input bit last);
    @(negedge clk);
    #1;
    chk("out_valid", bus.out_valid, 1);
    chk("out_bits", bus.out_bits, bits);
    chk("out_last", bus.out_last, last);
    chk("emit_ready", bus.code_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.code_valid = 1'b0;
    bus.code_len = 8'd0;
    bus.code_last = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_ready", bus.code_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", bus.word_count, 0);
    chk("rst_err", bus.len_err, 0);
    chk("rst_en", bus.arr_enable, 0);
    code(32, 0, 0, 0, 1);
    code(32, 0, 32, 1, 1);
    code(32, 0, 64, 1, 1);
    code(32, 0, 96, 1, 1);
    take(128, 0);
    @(negedge clk);
    #1;
    chk("t1_count", bus.word_count, 1);
    chk("t1_ready", bus.code_ready, 1);
    code(100, 0, 0, 0, 1);
    code(40, 0, 100, 1, 1);
    take(128, 0);
    code(10, 0, 12, 1, 1);
    chk("t2_count", bus.word_count, 2);
    do_reset();
    code(20, 0, 0, 0, 1);
    code(30, 1, 20, 1, 1);
    take(50, 1);
    @(negedge clk);
    #1;
    chk("t3_ready", bus.code_ready, 1);
    chk("t3_valid", bus.out_valid, 0);
    chk("t3_count", bus.word_count, 1);
    code(120, 0, 0, 0, 1);
    code(100, 1, 120, 1, 1);
    take(128, 0);
    take(92, 1);
    @(negedge clk);
    #1;
    chk("t4_ready", bus.code_ready, 1);
    chk("t4_count", bus.word_count, 3);
    code(128, 0, 0, 0, 1);
    bus.code_valid = 1'b1;
    bus.code_len = 8'd8;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_ready", bus.code_ready, 0);
      chk("stall_en", bus.arr_enable, 0);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_bits", bus.out_bits, 128);
      chk("stall_count", bus.word_count, 3);
    end
    bus.code_valid = 1'b0;
    take(128, 0);
    @(negedge clk);
    #1;
    chk("t5_count", bus.word_count, 4);
    code(100, 0, 0, 0, 1);
    code(100, 0, 100, 1, 1);
    @(negedge clk);
    #1;
    chk("t6_pre_valid", bus.out_valid, 1);
    do_reset();
    @(negedge clk);
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_ready", bus.code_ready, 1);
    chk("t6_count", bus.word_count, 0);
    chk("t6_err0", bus.len_err, 0);
    code(0, 0, 0, 0, 0);
    chk("t6_err1", bus.len_err, 1);
    chk("t6_noemit", bus.out_valid, 0);
    code(200, 0, 0, 0, 1);
    take(128, 0);
    @(negedge clk);
    #1;
    chk("t6_err_sticky", bus.len_err, 1);
    chk("t6_end_count", bus.word_count, 1);
    chk("t6_end_ready", bus.code_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
